hash_bank_loader: RTL

Loads the target NTLM hash table into the cracker. Accepts 128-bit target hashes as a stream of 32-bit words and assembles them into the flat 64×128-bit hash bank. The bank feeds the hash comparator, with a per-slot valid mask and a ready flag. It is the write side of the bank that the comparator reads every cycle.

---
 rtl/hash_bank_loader.sv | 138 +++++++++++++
 1 files changed

// File: rtl/hash_bank_loader.sv
// hash_bank_loader: packs 32-bit words into the 64x128 hash bank; a word is visible on hash_bank 1 cycle after acceptance.
// Backpressure: wready is high only in LOAD and words are not buffered; defining HASH_BANK_CLEAR_EN zeroes the bank on load_start.
module hash_bank_loader #(
  parameter int NUM_HASHES = 64,
  parameter int HASH_W     = 128,
  parameter int WORD_W     = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  load_start,
  input  logic                                  load_done,
  input  logic [WORD_W-1:0]                     wdata,
  input  logic                                  wvalid,
  output logic                                  wready,
  output logic [0:NUM_HASHES*HASH_W-1]          hash_bank,
  output logic [0:NUM_HASHES-1]                 hash_valid,
  output logic [$clog2(NUM_HASHES+1)-1:0]       bank_count,
  output logic                                  bank_ready,
  output logic                                  load_err
);

  localparam int WPH    = HASH_W / WORD_W;
  localparam int WCNT_W = $clog2(WPH);
  localparam int SLOT_W = $clog2(NUM_HASHES);
  localparam int CNT_W  = $clog2(NUM_HASHES + 1);
  localparam int NWORDS = NUM_HASHES * WPH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [WCNT_W-1:0]         wcnt_q, wcnt_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [0:NUM_HASHES-1]     valid_q, valid_d;
  logic                      err_q, err_d;
  logic [WORD_W-1:0]         mem_q [NWORDS];

  logic                      accept;
  logic                      last_word;
  logic                      partial;
  logic [SLOT_W-1:0]         slot;
  logic [SLOT_W+WCNT_W-1:0]  waddr;

  // A restart takes priority over any word presented in the same cycle.
  assign accept    = wvalid && (state_q == LOAD) && !load_start;
  assign last_word = accept && (wcnt_q == WCNT_W'(WPH - 1));
  assign slot      = count_q[SLOT_W-1:0];
  assign waddr     = {slot, wcnt_q};
  assign partial   = accept ? !last_word : (wcnt_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      count_q <= count_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    count_d = count_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (load_start) begin
      state_d = LOAD;
      wcnt_d  = '0;
      count_d = '0;
      valid_d = '0;
      err_d   = 1'b0;
    end else if (state_q == LOAD) begin
      if (accept) begin
        if (last_word) begin
          valid_d[slot] = 1'b1;
          count_d       = count_q + 1'b1;
          wcnt_d        = '0;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      if (last_word && (count_q == CNT_W'(NUM_HASHES - 1))) begin
        state_d = DONE;
      end
      // A 4th word arriving with load_done has already committed above.
      if (load_done) begin
        state_d = DONE;
        if (partial) begin
          err_d  = 1'b1;
          wcnt_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < NWORDS; j++) begin
        mem_q[j] <= '0;
      end
    end
`ifdef HASH_BANK_CLEAR_EN
    else if (load_start) begin
      for (int j = 0; j < NWORDS; j++) begin
        mem_q[j] <= '0;
      end
    end
`endif
    else if (accept) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Word 0 of each slot lands on the lowest flat-bus indices, i.e. the MSW.
  for (genvar j = 0; j < NWORDS; j++) begin : g_flat
    assign hash_bank[j*WORD_W +: WORD_W] = mem_q[j];
  end

  always_comb begin
    wready     = (state_q == LOAD);
    bank_ready = (state_q == DONE);
  end

  assign hash_valid = valid_q;
  assign bank_count = count_q;
  assign load_err   = err_q;

endmodule
